// File: rtl/dp_pkg.sv
// -----------------------------------------------------------------------------
// dp_pkg
// Shared constants for the datapath control unit: resource indices (used both
// as enable bit positions and bus source codes), opcodes, ALU op codes,
// instruction classes, sequencer state encoding and IR field positions.
// -----------------------------------------------------------------------------
package dp_pkg;

   // Resource indices. R0..R15 map directly onto 0..15.
   localparam logic [4:0] RES_HI     = 5'd16;
   localparam logic [4:0] RES_LO     = 5'd17;
   localparam logic [4:0] RES_ZHIGH  = 5'd18;
   localparam logic [4:0] RES_ZLOW   = 5'd19;
   localparam logic [4:0] RES_PC     = 5'd20;
   localparam logic [4:0] RES_MDR    = 5'd21;
   localparam logic [4:0] RES_INPORT = 5'd22;
   localparam logic [4:0] RES_IR     = 5'd23;
   localparam logic [4:0] RES_Z      = 5'd24;
   localparam logic [4:0] RES_MAR    = 5'd25;
   localparam logic [4:0] RES_Y      = 5'd26;

   // Opcodes of the supported register-register ALU instructions.
   localparam logic [4:0] OP_ADD = 5'b00011;
   localparam logic [4:0] OP_SUB = 5'b00100;
   localparam logic [4:0] OP_AND = 5'b00101;
   localparam logic [4:0] OP_OR  = 5'b00110;
   localparam logic [4:0] OP_MUL = 5'b01111;
   localparam logic [4:0] OP_DIV = 5'b10000;
   localparam logic [4:0] OP_NEG = 5'b10001;
   localparam logic [4:0] OP_NOT = 5'b10010;

   // IR field positions.
   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RA_MSB  = 26;
   localparam int RA_LSB  = 23;
   localparam int RB_MSB  = 22;
   localparam int RB_LSB  = 19;
   localparam int RC_MSB  = 18;
   localparam int RC_LSB  = 15;

   typedef enum logic [3:0] {
      ALU_NOP = 4'd0,
      ALU_ADD = 4'd1,
      ALU_SUB = 4'd2,
      ALU_MUL = 4'd3,
      ALU_DIV = 4'd4,
      ALU_AND = 4'd5,
      ALU_OR  = 4'd6,
      ALU_NEG = 4'd7,
      ALU_NOT = 4'd8
   } alu_op_t;

   typedef enum logic [1:0] {
      CLS_NONE   = 2'd0,
      CLS_BINARY = 2'd1,
      CLS_WIDE   = 2'd2,
      CLS_UNARY  = 2'd3
   } instr_class_t;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_T0    = 4'd1,
      S_T1    = 4'd2,
      S_T2    = 4'd3,
      S_T3    = 4'd4,
      S_T4    = 4'd5,
      S_T5    = 4'd6,
      S_T6    = 4'd7,
      S_FAULT = 4'd8
   } state_t;

   // One-hot load mask for a single resource.
   function automatic logic [31:0] res_bit(input logic [4:0] idx);
      return 32'd1 << idx;
   endfunction

   // Bus source code, zero-extended to the 32-bit busSelect port.
   function automatic logic [31:0] bus_sel(input logic [4:0] idx);
      return {27'd0, idx};
   endfunction

endpackage

// File: rtl/instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
// Purely combinational IR decode for the control sequencer.
//   ir_in       in  32  IR register contents
//   alu_op      out  4  ALU operation code (ALU_NOP when illegal)
//   instr_class out  2  binary / wide / unary / none
//   illegal     out  1  opcode is not a supported ALU instruction
//   ra, rb, rc  out  4  register fields
// -----------------------------------------------------------------------------
module instr_decode
   import dp_pkg::*;
(
   input  logic [31:0]  ir_in,
   output alu_op_t      alu_op,
   output instr_class_t instr_class,
   output logic         illegal,
   output logic [3:0]   ra,
   output logic [3:0]   rb,
   output logic [3:0]   rc
);

   // Low IR bits carry no information for register-register instructions.
   logic w_unused;
   assign w_unused = ^ir_in[RC_LSB-1:0];

   assign ra = ir_in[RA_MSB:RA_LSB];
   assign rb = ir_in[RB_MSB:RB_LSB];
   assign rc = ir_in[RC_MSB:RC_LSB];

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path through the case can leave it unassigned and infer a latch.
      alu_op      = ALU_NOP;
      instr_class = CLS_NONE;
      case (ir_in[OPC_MSB:OPC_LSB])
         OP_ADD: begin alu_op = ALU_ADD; instr_class = CLS_BINARY; end
         OP_SUB: begin alu_op = ALU_SUB; instr_class = CLS_BINARY; end
         OP_AND: begin alu_op = ALU_AND; instr_class = CLS_BINARY; end
         OP_OR:  begin alu_op = ALU_OR;  instr_class = CLS_BINARY; end
         OP_MUL: begin alu_op = ALU_MUL; instr_class = CLS_WIDE;   end
         OP_DIV: begin alu_op = ALU_DIV; instr_class = CLS_WIDE;   end
         OP_NEG: begin alu_op = ALU_NEG; instr_class = CLS_UNARY;  end
         OP_NOT: begin alu_op = ALU_NOT; instr_class = CLS_UNARY;  end
         default: ;
      endcase
      illegal = (instr_class == CLS_NONE);
   end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Moore FSM that sequences the datapath through fetch (T0-T2) and execute
// (T3-T6) of register-register ALU instructions.
//   clk             in   1  rising-edge clock
//   clr             in   1  asynchronous active-low reset
//   run             in   1  run request, sampled at instruction boundaries
//   mem_rdy         in   1  memory read data valid, sampled in T1
//   ir_in           in  32  IR contents read back from the datapath
//   enable          out 32  register load mask (bit = resource index)
//   busSelect       out 32  bus source index in [4:0]
//   MD_Read         out  1  MDR loads from memory data
//   Control_Signals out  4  ALU op code
//   IncPC           out  1  PC increment
//   done            out  1  last execute cycle of an instruction
//   illegal         out  1  sequencer is in FAULT
//   state           out  4  current state (debug)
// -----------------------------------------------------------------------------
module control_sequencer
   import dp_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic        run,
   input  logic        mem_rdy,
   input  logic [31:0] ir_in,
   output logic [31:0] enable,
   output logic [31:0] busSelect,
   output logic        MD_Read,
   output logic [3:0]  Control_Signals,
   output logic        IncPC,
   output logic        done,
   output logic        illegal,
   output logic [3:0]  state
);

   state_t       r_state;
   state_t       w_next;
   state_t       w_boundary;
   alu_op_t      w_alu_op;
   instr_class_t w_class;
   logic         w_illegal;
   logic [3:0]   w_ra;
   logic [3:0]   w_rb;
   logic [3:0]   w_rc;

   instr_decode u_decode (
      .ir_in       (ir_in),
      .alu_op      (w_alu_op),
      .instr_class (w_class),
      .illegal     (w_illegal),
      .ra          (w_ra),
      .rb          (w_rb),
      .rc          (w_rc)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_boundary      = run ? S_T0 : S_IDLE;
      w_next          = r_state;
      enable          = '0;
      busSelect       = '0;
      MD_Read         = 1'b0;
      Control_Signals = '0;
      IncPC           = 1'b0;
      done            = 1'b0;
      illegal         = 1'b0;

      case (r_state)
         S_IDLE: if (run) w_next = S_T0;
         S_T0: begin
            busSelect = bus_sel(RES_PC);
            enable    = res_bit(RES_MAR) | res_bit(RES_PC);
            IncPC     = 1'b1;
            w_next    = S_T1;
         end
         S_T1: begin
            MD_Read = 1'b1;
            enable  = res_bit(RES_MDR);
            if (mem_rdy) w_next = S_T2;
         end
         S_T2: begin
            busSelect = bus_sel(RES_MDR);
            enable    = res_bit(RES_IR);
            w_next    = S_T3;
         end
         S_T3: begin
            // An illegal opcode drives nothing before locking up in FAULT.
            if (w_illegal) begin
               w_next = S_FAULT;
            end else if (w_class == CLS_UNARY) begin
               busSelect       = bus_sel({1'b0, w_rb});
               Control_Signals = w_alu_op;
               enable          = res_bit(RES_Z);
               w_next          = S_T4;
            end else begin
               busSelect = bus_sel({1'b0, w_rb});
               enable    = res_bit(RES_Y);
               w_next    = S_T4;
            end
         end
         S_T4: begin
            if (w_class == CLS_UNARY) begin
               busSelect = bus_sel(RES_ZLOW);
               enable    = res_bit({1'b0, w_ra});
               done      = 1'b1;
               w_next    = w_boundary;
            end else begin
               busSelect       = bus_sel({1'b0, w_rc});
               Control_Signals = w_alu_op;
               enable          = res_bit(RES_Z);
               w_next          = S_T5;
            end
         end
         S_T5: begin
            busSelect = bus_sel(RES_ZLOW);
            if (w_class == CLS_WIDE) begin
               enable = res_bit(RES_LO);
               w_next = S_T6;
            end else begin
               enable = res_bit({1'b0, w_ra});
               done   = 1'b1;
               w_next = w_boundary;
            end
         end
         S_T6: begin
            busSelect = bus_sel(RES_ZHIGH);
            enable    = res_bit(RES_HI);
            done      = 1'b1;
            w_next    = w_boundary;
         end
         S_FAULT: illegal = 1'b1;
         default: w_next = S_IDLE;
      endcase
   end

   assign state = r_state;

endmodule
